bp_me_l2_dma_arbiter: RTL and testbench
=======================================

// Module: bp_me_l2_dma_arbiter
// PURPOSE
//  Shares one DRAM DMA channel (bsg_cache dma_pkt/dma_data, one-beat-per-cycle links) between num_caches_p L2 bsg_cache banks.
//  Round-robin packet arbitration; tracks read/write ownership in order; returns read fill beats to, and takes write beats from, the owner.
//  Sits between the L2 banks of a multi-bank unicore/tile and the DRAM controller.
// PARAMETERS
//  num_caches_p      2    number of L2 banks (requesters), >=2
//  caddr_width_p     32   cache address width; dma_pkt = {write_not_read(1), addr(caddr_width_p)}
//  l2_fill_width_p   64   DMA data beat width
//  l2_block_width_p  512  L2 block width; beats/block B = l2_block_width_p/l2_fill_width_p (integer, >=1)
//  max_outstanding_p 4    depth of read and write ownership FIFOs
// PORTS
//  clk_i                input  1                        clock
//  reset_i              input  1                        sync active-high reset
//  dma_pkt_i            input  N*(caddr_width_p+1)      per-bank DMA packets
//  dma_pkt_v_i          input  N                        per-bank packet valid
//  dma_pkt_yumi_o       output N                        per-bank packet consumed
//  dma_data_o           output N*l2_fill_width_p        read fill beat broadcast to banks
//  dma_data_v_o         output N                        read fill valid (one-hot, owner only)
//  dma_data_ready_and_i input  N                        bank ready for fill beat
//  dma_data_i           input  N*l2_fill_width_p        per-bank write beats
//  dma_data_v_i         input  N                        per-bank write valid
//  dma_data_yumi_o      output N                        per-bank write beat consumed
//  mem_dma_pkt_o        output caddr_width_p+1          packet to DRAM
//  mem_dma_pkt_v_o      output 1                        packet valid
//  mem_dma_pkt_yumi_i   input  1                        DRAM consumed packet
//  mem_dma_data_i       input  l2_fill_width_p          read beat from DRAM
//  mem_dma_data_v_i     input  1                        read beat valid
//  mem_dma_data_ready_and_o output 1                    arbiter accepts read beat
//  mem_dma_data_o       output l2_fill_width_p          write beat to DRAM
//  mem_dma_data_v_o     output 1                        write beat valid
//  mem_dma_data_yumi_i  input  1                        DRAM consumed write beat
// BEHAVIOUR
//  Reset: RR pointer=0, both FIFOs empty, beat counters=0; all v/yumi/ready outputs 0 during and the cycle after reset.
//  Arbitration: winner = first asserted dma_pkt_v_i at/after pointer (wrapping). A bank is eligible only if its FIFO (rd or wr,
//   by write_not_read) is not full; full check uses registered count, same-cycle pop does NOT free a slot.
//  mem_dma_pkt_o/v_o = winner's packet, combinational, 0-cycle latency. On mem_dma_pkt_yumi_i: dma_pkt_yumi_o[winner]=1,
//   push winner id to rd or wr FIFO, pointer <= winner+1 (mod N). No yumi -> pointer holds; winner may change next cycle.
//  Read return: head=rd FIFO head. mem_dma_data_ready_and_o = !rd_empty & dma_data_ready_and_i[head];
//   dma_data_v_o[head] = mem_dma_data_v_i & !rd_empty; all banks see dma_data_o = mem_dma_data_i.
//   Beat handshake increments rd counter; at count B-1 counter->0 and FIFO pops. Beats with rd_empty are not accepted.
//  Write data: head=wr FIFO head. mem_dma_data_o = dma_data_i[head]; mem_dma_data_v_o = !wr_empty & dma_data_v_i[head];
//   dma_data_yumi_o[head] = mem_dma_data_yumi_i; B-beat counter pops FIFO on last beat. Write beats from non-head banks stall.
//  Read and write paths fully independent; packet accept, read beat and write beat may all occur in one cycle.
//  Push and pop same FIFO same cycle: both happen, count unchanged. B=1: every beat pops.
//  Reset mid-burst: counters/FIFOs cleared; in-flight DRAM traffic is lost (system-level reset required).
// CONFIGURATION
//  BP_ME_L2_DMA_ARBITER_PERF_EN defined: adds output grant_count_o [N*32], per-bank 32-bit count of accepted packets,
//   wraps at 2^32, reset to 0. Undefined: port and counters absent; all other behaviour identical.
// TESTING
//  N=2, both v_i, yumi every cycle, ptr=0 -> grants 0,1,0,1; pointer alternates.
//  Bank0 read A=0x100, B=8, 8 DRAM beats 0..7 -> dma_data_v_o=2'b01 for 8 beats, FIFO empty after beat 7.
//  Bank1 write, bank0 drives data_v_i -> no DRAM beat; bank1 8 beats -> dma_data_yumi_o[1] x8, FIFO pops.
//  4 reads outstanding (max) -> 5th read not granted until a pop, write from same bank still granted.
//  Reads from 0 then 1, ready_and_i[0]=0 -> mem_dma_data_ready_and_o=0, bank1 data not reordered ahead.
//  Reset asserted mid read burst beat 3 -> all outputs 0 next cycle, FIFOs empty, ptr=0.

Source files
------------

// File: rtl/bp_me_l2_dma_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : bp_me_l2_dma_arbiter                                         |
// | Desc     : Shares one DRAM DMA channel between NUM_CACHES_P L2 banks.   |
// |            Round-robin packet arbitration, in-order read and write      |
// |            ownership FIFOs that steer fill beats to / write beats from  |
// |            the owning bank.                                             |
// | Option   : `define BP_ME_L2_DMA_ARBITER_PERF_EN adds grant_count_o,     |
// |            a per-bank 32-bit count of accepted packets.                 |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module bp_me_l2_dma_arbiter #(
    parameter int NUM_CACHES_P      = 2,
    parameter int CADDR_WIDTH_P     = 32,
    parameter int L2_FILL_WIDTH_P   = 64,
    parameter int L2_BLOCK_WIDTH_P  = 512,
    parameter int MAX_OUTSTANDING_P = 4
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic [NUM_CACHES_P*(CADDR_WIDTH_P+1)-1:0]   dma_pkt_i,
    input  logic [NUM_CACHES_P-1:0]                     dma_pkt_v_i,
    output logic [NUM_CACHES_P-1:0]                     dma_pkt_yumi_o,
    output logic [NUM_CACHES_P*L2_FILL_WIDTH_P-1:0]     dma_data_o,
    output logic [NUM_CACHES_P-1:0]                     dma_data_v_o,
    input  logic [NUM_CACHES_P-1:0]                     dma_data_ready_and_i,
    input  logic [NUM_CACHES_P*L2_FILL_WIDTH_P-1:0]     dma_data_i,
    input  logic [NUM_CACHES_P-1:0]                     dma_data_v_i,
    output logic [NUM_CACHES_P-1:0]                     dma_data_yumi_o,
    output logic [CADDR_WIDTH_P:0]                      mem_dma_pkt_o,
    output logic                                        mem_dma_pkt_v_o,
    input  logic                                        mem_dma_pkt_yumi_i,
    input  logic [L2_FILL_WIDTH_P-1:0]                  mem_dma_data_i,
    input  logic                                        mem_dma_data_v_i,
    output logic                                        mem_dma_data_ready_and_o,
    output logic [L2_FILL_WIDTH_P-1:0]                  mem_dma_data_o,
    output logic                                        mem_dma_data_v_o,
    input  logic                                        mem_dma_data_yumi_i
`ifdef BP_ME_L2_DMA_ARBITER_PERF_EN
    ,
    output logic [NUM_CACHES_P*32-1:0]                  grant_count_o
`endif
);

    localparam int c_pkt_w  = CADDR_WIDTH_P + 1;
    localparam int c_beats  = L2_BLOCK_WIDTH_P / L2_FILL_WIDTH_P;
    localparam int c_id_w   = $clog2(NUM_CACHES_P);
    localparam int c_beat_w = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_slot_w = (MAX_OUTSTANDING_P > 1) ? $clog2(MAX_OUTSTANDING_P) : 1;
    localparam int c_cnt_w  = $clog2(MAX_OUTSTANDING_P + 1);
    localparam int c_rd     = 0;
    localparam int c_wr     = 1;
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);
    localparam logic [c_id_w-1:0]   c_last_id   = c_id_w'(NUM_CACHES_P - 1);

    logic                       r_rst_d1;
    logic                       w_block;
    logic [c_id_w-1:0]          r_ptr;
    logic [c_id_w-1:0]          w_winner;
    logic [c_id_w-1:0]          w_idx;
    logic                       w_any;
    logic                       w_grant;
    logic [c_pkt_w-1:0]         w_pkt   [NUM_CACHES_P];
    logic [L2_FILL_WIDTH_P-1:0] w_wdata [NUM_CACHES_P];
    logic [NUM_CACHES_P-1:0]    w_eligible;
    logic                       w_push  [2];
    logic                       w_pop   [2];
    logic                       w_full  [2];
    logic                       w_empty [2];
    logic [c_id_w-1:0]          w_head_id [2];
    logic [c_beat_w-1:0]        r_rd_beat;
    logic [c_beat_w-1:0]        r_wr_beat;
    logic                       w_rd_beat;
    logic                       w_wr_beat;

    // Per-bank unpacking; a bank may only compete if the FIFO its packet needs has room
    for (genvar i = 0; i < NUM_CACHES_P; i++) begin : g_bank
        assign w_pkt[i]      = dma_pkt_i[i*c_pkt_w +: c_pkt_w];
        assign w_wdata[i]    = dma_data_i[i*L2_FILL_WIDTH_P +: L2_FILL_WIDTH_P];
        assign w_eligible[i] = dma_pkt_v_i[i] &
                               ~(w_pkt[i][CADDR_WIDTH_P] ? w_full[c_wr] : w_full[c_rd]);
        assign dma_data_o[i*L2_FILL_WIDTH_P +: L2_FILL_WIDTH_P] = mem_dma_data_i;
    end

    // Outputs are held quiet while in reset and for one cycle after it
    always_ff @(posedge clk_i) begin
        r_rst_d1 <= reset_i;
    end
    assign w_block = reset_i | r_rst_d1;

    // Round-robin search: scanning downward so the lowest offset from r_ptr wins last
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int off = NUM_CACHES_P - 1; off >= 0; off--) begin
            w_idx = c_id_w'((int'(r_ptr) + off) % NUM_CACHES_P);
            if (w_eligible[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign mem_dma_pkt_v_o  = w_any & ~w_block;
    assign mem_dma_pkt_o    = w_pkt[w_winner];
    assign w_grant          = mem_dma_pkt_v_o & mem_dma_pkt_yumi_i;
    assign w_push[c_rd]     = w_grant & ~w_pkt[w_winner][CADDR_WIDTH_P];
    assign w_push[c_wr]     = w_grant &  w_pkt[w_winner][CADDR_WIDTH_P];

    // Pointer moves past the bank that was just accepted; holds otherwise
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_winner == c_last_id) ? '0 : w_winner + 1'b1;
        end
    end

    // Two ownership FIFOs (read, write) holding bank ids in grant order
    for (genvar f = 0; f < 2; f++) begin : g_fifo
        logic [c_id_w-1:0]   r_mem [MAX_OUTSTANDING_P];
        logic [c_slot_w-1:0] r_head;
        logic [c_slot_w-1:0] r_tail;
        logic [c_cnt_w-1:0]  r_count;

        assign w_full[f]    = (r_count == c_cnt_w'(MAX_OUTSTANDING_P));
        assign w_empty[f]   = (r_count == '0);
        assign w_head_id[f] = r_mem[r_head];

        // Push granted id at tail, pop head on the last beat of its burst
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                for (int s = 0; s < MAX_OUTSTANDING_P; s++) begin
                    r_mem[s] <= '0;
                end
            end else begin
                if (w_push[f]) begin
                    r_mem[r_tail] <= w_winner;
                    r_tail <= (r_tail == c_slot_w'(MAX_OUTSTANDING_P - 1)) ? '0 : r_tail + 1'b1;
                end
                if (w_pop[f]) begin
                    r_head <= (r_head == c_slot_w'(MAX_OUTSTANDING_P - 1)) ? '0 : r_head + 1'b1;
                end
                if (w_push[f] & ~w_pop[f]) begin
                    r_count <= r_count + 1'b1;
                end else if (~w_push[f] & w_pop[f]) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    // Read return: only the oldest read owner may take a fill beat
    assign mem_dma_data_ready_and_o = ~w_block & ~w_empty[c_rd] & dma_data_ready_and_i[w_head_id[c_rd]];
    assign w_rd_beat                = mem_dma_data_v_i & mem_dma_data_ready_and_o;
    assign w_pop[c_rd]              = w_rd_beat & (r_rd_beat == c_last_beat);

    // Write data: only the oldest write owner may send a beat
    assign mem_dma_data_o   = w_wdata[w_head_id[c_wr]];
    assign mem_dma_data_v_o = ~w_block & ~w_empty[c_wr] & dma_data_v_i[w_head_id[c_wr]];
    assign w_wr_beat        = mem_dma_data_v_o & mem_dma_data_yumi_i;
    assign w_pop[c_wr]      = w_wr_beat & (r_wr_beat == c_last_beat);

    // Beat counters track position within the current read and write bursts
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rd_beat <= '0;
            r_wr_beat <= '0;
        end else begin
            if (w_rd_beat) begin
                r_rd_beat <= (r_rd_beat == c_last_beat) ? '0 : r_rd_beat + 1'b1;
            end
            if (w_wr_beat) begin
                r_wr_beat <= (r_wr_beat == c_last_beat) ? '0 : r_wr_beat + 1'b1;
            end
        end
    end

    // One-hot steering of per-bank handshake outputs
    always_comb begin
        dma_pkt_yumi_o  = '0;
        dma_data_v_o    = '0;
        dma_data_yumi_o = '0;
        if (w_grant) begin
            dma_pkt_yumi_o[w_winner] = 1'b1;
        end
        if (~w_block & ~w_empty[c_rd] & mem_dma_data_v_i) begin
            dma_data_v_o[w_head_id[c_rd]] = 1'b1;
        end
        if (w_wr_beat) begin
            dma_data_yumi_o[w_head_id[c_wr]] = 1'b1;
        end
    end

`ifdef BP_ME_L2_DMA_ARBITER_PERF_EN
    for (genvar i = 0; i < NUM_CACHES_P; i++) begin : g_perf
        logic [31:0] r_grant_count;

        // Free-running count of packets accepted from this bank
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                r_grant_count <= '0;
            end else if (w_grant && (w_winner == c_id_w'(i))) begin
                r_grant_count <= r_grant_count + 32'd1;
            end
        end
        assign grant_count_o[i*32 +: 32] = r_grant_count;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_me_l2_dma_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_bp_me_l2_dma_arbiter                                      |
// | Desc     : Random bank/DRAM agents with a queue-based scoreboard for    |
// |            bp_me_l2_dma_arbiter (2 banks, 8 beats/block, depth 4).      |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module tb_bp_me_l2_dma_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int FW = 64;
    localparam int BW = 512;
    localparam int D  = 4;
    localparam int B  = BW / FW;
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [7:0]    bank;
        logic [FW-1:0] data;
    } beat_t;

    logic            clk;
    logic            reset_i;
    logic [N*PW-1:0] dma_pkt_i;
    logic [N-1:0]    dma_pkt_v_i;
    logic [N-1:0]    dma_pkt_yumi_o;
    logic [N*FW-1:0] dma_data_o;
    logic [N-1:0]    dma_data_v_o;
    logic [N-1:0]    dma_data_ready_and_i;
    logic [N*FW-1:0] dma_data_i;
    logic [N-1:0]    dma_data_v_i;
    logic [N-1:0]    dma_data_yumi_o;
    logic [PW-1:0]   mem_dma_pkt_o;
    logic            mem_dma_pkt_v_o;
    logic            mem_dma_pkt_yumi_i;
    logic [FW-1:0]   mem_dma_data_i;
    logic            mem_dma_data_v_i;
    logic            mem_dma_data_ready_and_o;
    logic [FW-1:0]   mem_dma_data_o;
    logic            mem_dma_data_v_o;
    logic            mem_dma_data_yumi_i;
`ifdef BP_ME_L2_DMA_ARBITER_PERF_EN
    logic [N*32-1:0] grant_count_o;
`endif

    bp_me_l2_dma_arbiter #(
        .NUM_CACHES_P      (N),
        .CADDR_WIDTH_P     (AW),
        .L2_FILL_WIDTH_P   (FW),
        .L2_BLOCK_WIDTH_P  (BW),
        .MAX_OUTSTANDING_P (D)
    ) dut (
        .clk_i                    (clk),
        .reset_i                  (reset_i),
        .dma_pkt_i                (dma_pkt_i),
        .dma_pkt_v_i              (dma_pkt_v_i),
        .dma_pkt_yumi_o           (dma_pkt_yumi_o),
        .dma_data_o               (dma_data_o),
        .dma_data_v_o             (dma_data_v_o),
        .dma_data_ready_and_i     (dma_data_ready_and_i),
        .dma_data_i               (dma_data_i),
        .dma_data_v_i             (dma_data_v_i),
        .dma_data_yumi_o          (dma_data_yumi_o),
        .mem_dma_pkt_o            (mem_dma_pkt_o),
        .mem_dma_pkt_v_o          (mem_dma_pkt_v_o),
        .mem_dma_pkt_yumi_i       (mem_dma_pkt_yumi_i),
        .mem_dma_data_i           (mem_dma_data_i),
        .mem_dma_data_v_i         (mem_dma_data_v_i),
        .mem_dma_data_ready_and_o (mem_dma_data_ready_and_o),
        .mem_dma_data_o           (mem_dma_data_o),
        .mem_dma_data_v_o         (mem_dma_data_v_o),
        .mem_dma_data_yumi_i      (mem_dma_data_yumi_i)
`ifdef BP_ME_L2_DMA_ARBITER_PERF_EN
        ,
        .grant_count_o            (grant_count_o)
`endif
    );

    // Scoreboard queues: expected fill owners per beat, expected write beats in order
    int unsigned   rd_exp_bank[$];
    beat_t         wr_exp[$];
    // Stimulus-side agent state
    beat_t         bank_beats[$];
    logic [PW-1:0] bank_pkt [N];
    bit            bank_has [N];
    int            dram_rd_pending;
    bit            issue_en;
    int            n_vec;
    int            n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Agents: banks issue and hold packets, banks/DRAM stream beats; expectations pushed on grant
    initial begin : driver
        bit         s_rst;
        logic [N-1:0] s_pkt_yumi;
        logic [N-1:0] s_wyumi;
        bit         s_mem_rd;
        bit         s_rd_hs;
        forever begin
            @(negedge clk);
            s_rst      = reset_i;
            s_pkt_yumi = dma_pkt_yumi_o;
            s_wyumi    = dma_data_yumi_o;
            s_mem_rd   = mem_dma_pkt_v_o & mem_dma_pkt_yumi_i & ~mem_dma_pkt_o[AW];
            s_rd_hs    = mem_dma_data_v_i & mem_dma_data_ready_and_o;
            @(posedge clk);
            #1;
            if (s_rst) begin
                for (int i = 0; i < N; i++) bank_has[i] = 1'b0;
                bank_beats.delete();
                dram_rd_pending = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (s_pkt_yumi[i] && bank_has[i]) begin
                        bank_has[i] = 1'b0;
                        if (bank_pkt[i][AW]) begin
                            for (int k = 0; k < B; k++) begin
                                beat_t bt;
                                bt.bank = 8'(i);
                                bt.data = {$urandom, $urandom};
                                bank_beats.push_back(bt);
                                wr_exp.push_back(bt);
                            end
                        end else begin
                            for (int k = 0; k < B; k++) rd_exp_bank.push_back(i);
                        end
                    end
                    if (s_wyumi[i]) begin
                        for (int k = 0; k < bank_beats.size(); k++) begin
                            if (bank_beats[k].bank == 8'(i)) begin
                                bank_beats.delete(k);
                                break;
                            end
                        end
                    end
                end
                if (s_mem_rd) dram_rd_pending += B;
                if (s_rd_hs && dram_rd_pending > 0) dram_rd_pending--;
            end
            for (int i = 0; i < N; i++) begin
                bit found;
                if (!bank_has[i] && issue_en && $urandom_range(0, 99) < 40) begin
                    bank_has[i] = 1'b1;
                    bank_pkt[i] = {1'($urandom_range(0, 99) < 45), 32'($urandom)};
                end
                dma_pkt_v_i[i]          = bank_has[i];
                dma_pkt_i[i*PW +: PW]   = bank_has[i] ? bank_pkt[i] : PW'({$urandom, $urandom});
                dma_data_ready_and_i[i] = ($urandom_range(0, 99) < 75);
                found = 1'b0;
                dma_data_i[i*FW +: FW]  = {$urandom, $urandom};
                for (int k = 0; k < bank_beats.size(); k++) begin
                    if (!found && bank_beats[k].bank == 8'(i)) begin
                        found = 1'b1;
                        dma_data_i[i*FW +: FW] = bank_beats[k].data;
                    end
                end
                dma_data_v_i[i] = found ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 20);
            end
            mem_dma_data_i   = {$urandom, $urandom};
            mem_dma_data_v_i = (dram_rd_pending > 0) ? ($urandom_range(0, 99) < 70)
                                                     : ($urandom_range(0, 99) < 15);
            #1;
            mem_dma_pkt_yumi_i  = mem_dma_pkt_v_o  && ($urandom_range(0, 99) < 65);
            mem_dma_data_yumi_i = mem_dma_data_v_o && ($urandom_range(0, 99) < 70);
        end
    end

    // Monitor: reference arbitration and ownership order, compare every cycle
    initial begin : monitor
        bit prev_rst;
        int ptr_m;
        prev_rst = 1'b1;
        ptr_m    = 0;
        forever begin
            @(negedge clk);
            if (reset_i || prev_rst) begin
                chk("reset_quiet", {mem_dma_pkt_v_o, dma_pkt_yumi_o, dma_data_v_o,
                     mem_dma_data_ready_and_o, mem_dma_data_v_o, dma_data_yumi_o}, '0);
                if (reset_i) begin
                    rd_exp_bank.delete();
                    wr_exp.delete();
                    ptr_m = 0;
                end
            end else begin
                int rd_out, wr_out, win;
                rd_out = (rd_exp_bank.size() + B - 1) / B;
                wr_out = (wr_exp.size() + B - 1) / B;
                win = -1;
                for (int off = 0; off < N; off++) begin
                    int b;
                    b = (ptr_m + off) % N;
                    if (win < 0 && dma_pkt_v_i[b] &&
                        (dma_pkt_i[b*PW + AW] ? (wr_out < D) : (rd_out < D))) win = b;
                end
                chk("pkt_v", mem_dma_pkt_v_o, win >= 0);
                if (win >= 0) chk("pkt", mem_dma_pkt_o, dma_pkt_i[win*PW +: PW]);
                chk("pkt_yumi", dma_pkt_yumi_o,
                    (win >= 0 && mem_dma_pkt_yumi_i) ? (1 << win) : 0);
                if (win >= 0 && mem_dma_pkt_yumi_i) ptr_m = (win + 1) % N;

                chk("rd_ready", mem_dma_data_ready_and_o,
                    rd_exp_bank.size() > 0 && dma_data_ready_and_i[rd_exp_bank[0]]);
                chk("rd_v", dma_data_v_o,
                    (rd_exp_bank.size() > 0 && mem_dma_data_v_i) ? (1 << rd_exp_bank[0]) : 0);
                if (mem_dma_data_v_i && mem_dma_data_ready_and_o) begin
                    chk("rd_beat_owned", rd_exp_bank.size() > 0, 1'b1);
                    chk("rd_data", dma_data_o, {N{mem_dma_data_i}});
                    if (rd_exp_bank.size() > 0) void'(rd_exp_bank.pop_front());
                end

                chk("wr_v", mem_dma_data_v_o,
                    wr_exp.size() > 0 && dma_data_v_i[wr_exp[0].bank]);
                if (mem_dma_data_v_o && mem_dma_data_yumi_i) begin
                    if (wr_exp.size() == 0) begin
                        chk("wr_beat_owned", 1'b0, 1'b1);
                    end else begin
                        chk("wr_data", mem_dma_data_o, wr_exp[0].data);
                        chk("wr_yumi", dma_data_yumi_o, 1 << wr_exp[0].bank);
                        void'(wr_exp.pop_front());
                    end
                end else begin
                    chk("wr_yumi_idle", dma_data_yumi_o, 0);
                end
            end
            prev_rst = reset_i;
        end
    end

    // Test sequence: reset, random traffic, reset mid read burst, more traffic, drain
    initial begin : control
        bit hit;
        n_vec                = 0;
        n_err                = 0;
        issue_en             = 1'b0;
        dram_rd_pending      = 0;
        reset_i              = 1'b1;
        dma_pkt_i            = '0;
        dma_pkt_v_i          = '0;
        dma_data_ready_and_i = '0;
        dma_data_i           = '0;
        dma_data_v_i         = '0;
        mem_dma_pkt_yumi_i   = 1'b0;
        mem_dma_data_i       = '0;
        mem_dma_data_v_i     = 1'b0;
        mem_dma_data_yumi_i  = 1'b0;
        for (int i = 0; i < N; i++) begin
            bank_has[i] = 1'b0;
            bank_pkt[i] = '0;
        end
        repeat (4) @(posedge clk);
        #1 reset_i = 1'b0;
        issue_en = 1'b1;
        repeat (2500) @(posedge clk);

        hit = 1'b0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(negedge clk);
            if (rd_exp_bank.size() > 0 && (rd_exp_bank.size() % B) == B - 3) hit = 1'b1;
        end
        chk("midburst_reached", hit, 1'b1);
        @(posedge clk);
        #1 reset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        repeat (2000) @(posedge clk);

        issue_en = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            if (rd_exp_bank.size() == 0 && wr_exp.size() == 0 && !bank_has[0] && !bank_has[1]) break;
        end
        @(negedge clk);
        chk("drain_rd", rd_exp_bank.size(), 0);
        chk("drain_wr", wr_exp.size(), 0);
        chk("drain_pkt_v", mem_dma_pkt_v_o, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
